// File: rtl/ftdi_tx_mass_gen_pkg.sv
// Shared state encoding and tail-beat keep decode for the TX mass generator.
package ftdi_tx_mass_gen_pkg;

  typedef enum logic {
    S_LEN = 1'b0,
    S_TX  = 1'b1
  } state_e;

  localparam int BEAT_BYTES = 4;

  // Keep mask for a final beat carrying 1..3 valid bytes.
  function automatic logic [3:0] tail_keep(input logic [1:0] n);
    logic [3:0] k;
    case (n)
      2'd1:    k = 4'h1;
      2'd2:    k = 4'h3;
      2'd3:    k = 4'h7;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ftdi_tx_mass_gen.sv
// Collects a 4-byte LE length from RX, then streams that many counting-pattern bytes on 32-bit TX.
// First TX beat one cycle after the 4th length byte; beats held stable under tx_tready backpressure.
module ftdi_tx_mass_gen
  import ftdi_tx_mass_gen_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rx_tready,
  input  logic        rx_tvalid,
  input  logic [7:0]  rx_tdata,
  input  logic        tx_tready,
  output logic        tx_tvalid,
  output logic [31:0] tx_tdata,
  output logic [3:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        busy,
  output logic [15:0] xfer_cnt
);

  localparam int BEAT_W = LEN_W - 2;

  state_e             state_q, state_d;
  logic [LEN_W-9:0]   len_q, len_d;
  logic [1:0]         idx_q, idx_d;
  logic [LEN_W-1:0]   left_q, left_d;
  logic [LEN_W-1:0]   len_full;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [15:0]        xfer_q, xfer_d;
  logic [7:0]         base;
  logic               in_tx;
  logic               last_beat;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    left_d   = left_q;
    beat_d   = beat_q;
    xfer_d   = xfer_q;
    len_full = {rx_tdata, len_q};

    case (state_q)
      S_LEN: begin
        if (rx_tvalid) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: len_d[7:0]   = rx_tdata;
            2'd1: len_d[15:8]  = rx_tdata;
            2'd2: len_d[23:16] = rx_tdata;
            default: begin
              left_d = len_full;
              beat_d = '0;
              // A zero-length request completes without ever raising tx_tvalid.
              if (len_full == '0) begin
                xfer_d = xfer_q + 16'd1;
              end else begin
                state_d = S_TX;
              end
            end
          endcase
        end
      end
      S_TX: begin
        if (tx_tready) begin
          beat_d = beat_q + BEAT_W'(1);
          left_d = (left_q > LEN_W'(BEAT_BYTES)) ? left_q - LEN_W'(BEAT_BYTES) : '0;
          if (left_q <= LEN_W'(BEAT_BYTES)) begin
            state_d = S_LEN;
            xfer_d  = xfer_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN;
      len_q   <= '0;
      idx_q   <= '0;
      left_q  <= '0;
      beat_q  <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      beat_q  <= beat_d;
      xfer_q  <= xfer_d;
    end
  end

  // Stream outputs decode only registered state, so they cannot change while stalled.
  assign in_tx     = (state_q == S_TX);
  assign last_beat = (left_q <= LEN_W'(BEAT_BYTES));
  assign base      = {beat_q[5:0], 2'b00};

  assign rx_tready = ~in_tx;
  assign tx_tvalid = in_tx;
  assign busy      = in_tx;
  assign xfer_cnt  = xfer_q;
  assign tx_tlast  = in_tx & last_beat;
  assign tx_tdata  = in_tx ? {base + 8'd3, base + 8'd2, base + 8'd1, base} : 32'h0;
  assign tx_tkeep  = !in_tx ? 4'h0 :
                     (left_q >= LEN_W'(BEAT_BYTES)) ? 4'hF : tail_keep(left_q[1:0]);

endmodule

// File: tb/tb_ftdi_tx_mass_gen.sv
// Self-checking bench: directed and random lengths against a byte-stream reference model.
module tb_ftdi_tx_mass_gen;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_tready;
  logic        rx_tvalid;
  logic [7:0]  rx_tdata;
  logic        tx_tready;
  logic        tx_tvalid;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep;
  logic        tx_tlast;
  logic        busy;
  logic [15:0] xfer_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] xfer_model = 16'd0;
  logic [7:0]  rx_bytes[$];
  beat_t       exp_q[$];

  ftdi_tx_mass_gen #(.LEN_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_tready (rx_tready),
    .rx_tvalid (rx_tvalid),
    .rx_tdata  (rx_tdata),
    .tx_tready (tx_tready),
    .tx_tvalid (tx_tvalid),
    .tx_tdata  (tx_tdata),
    .tx_tkeep  (tx_tkeep),
    .tx_tlast  (tx_tlast),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: stream byte k is k mod 256; beats are 4-byte slices of the N-byte stream.
  task automatic push_len(input logic [31:0] len);
    longint n;
    longint nb;
    longint rem;
    beat_t  b;
    n  = longint'(len);
    nb = (n + 3) / 4;
    for (int j = 0; j < 4; j++) rx_bytes.push_back(8'(len >> (8 * j)));
    for (longint i = 0; i < nb; i++) begin
      rem = n - 4 * i;
      for (int j = 0; j < 4; j++) b.d[8*j +: 8] = 8'((4 * i + j) % 256);
      b.k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
      b.l = (i == nb - 1);
      exp_q.push_back(b);
    end
    xfer_model = xfer_model + 16'd1;
  endtask

  // Feeds all queued RX bytes while consuming up to max_beats TX beats.
  task automatic run_xfer(input bit rand_ready, input int max_beats);
    int nb;
    int got;
    int tcyc;
    int fcyc;
    int nfed;
    int hs4;
    int first_vld;
    bit prev_stall;
    bit hs;
    beat_t prev;
    nb = (max_beats < exp_q.size()) ? max_beats : exp_q.size();
    got = 0; tcyc = 0; fcyc = 0; nfed = 0; hs4 = -1; first_vld = -1; prev_stall = 0;
    prev = '0;
    fork
      begin
        while (nfed < rx_bytes.size() && fcyc < 4000) begin
          rx_tvalid = 1'b1;
          rx_tdata  = rx_bytes[nfed];
          hs = rx_tready;
          if (hs && nfed == 3) hs4 = cyc;
          step();
          if (hs) nfed++;
          fcyc++;
        end
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
      end
      begin
        while (got < nb && tcyc < 4000) begin
          tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (prev_stall) begin
            check("hold_vld",  {31'd0, tx_tvalid}, 32'd1);
            check("hold_data", tx_tdata, prev.d);
            check("hold_keep", {28'd0, tx_tkeep}, {28'd0, prev.k});
            check("hold_last", {31'd0, tx_tlast}, {31'd0, prev.l});
          end
          if (tx_tvalid && first_vld < 0) first_vld = cyc;
          if (tx_tvalid && tx_tready) begin
            check("beat_data", tx_tdata, exp_q[got].d);
            check("beat_keep", {28'd0, tx_tkeep}, {28'd0, exp_q[got].k});
            check("beat_last", {31'd0, tx_tlast}, {31'd0, exp_q[got].l});
            got++;
          end
          prev_stall = tx_tvalid && !tx_tready;
          prev = '{d: tx_tdata, k: tx_tkeep, l: tx_tlast};
          step();
          tcyc++;
        end
        tx_tready = 1'b0;
      end
    join
    check("rx_all_fed", nfed, rx_bytes.size());
    check("tx_beats", got, nb);
    if (nb > 0) check("latency", first_vld - hs4, 1);
    rx_bytes.delete();
    exp_q.delete();
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_rdy"},  {31'd0, rx_tready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_vld"},  {31'd0, tx_tvalid}, 32'd0);
    check({tag, "_xfer"}, {16'd0, xfer_cnt}, {16'd0, xfer_model});
  endtask

  initial begin
    logic [31:0] rl;
    rst = 1'b1; rx_tvalid = 1'b0; rx_tdata = 8'h00; tx_tready = 1'b0;
    repeat (2) step();
    check("rst_rdy",  {31'd0, rx_tready}, 32'd1);
    check("rst_vld",  {31'd0, tx_tvalid}, 32'd0);
    check("rst_keep", {28'd0, tx_tkeep}, 32'd0);
    check("rst_last", {31'd0, tx_tlast}, 32'd0);
    check("rst_data", tx_tdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_xfer", {16'd0, xfer_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // Length 8, full-rate sink.
    push_len(32'd8);
    run_xfer(1'b0, 1000);
    idle_checks("len8");

    // Length 6: partial tail beat.
    push_len(32'd6);
    run_xfer(1'b0, 1000);
    idle_checks("len6");

    // Length 0: nothing on TX, stays ready.
    push_len(32'd0);
    run_xfer(1'b0, 1000);
    for (int i = 0; i < 3; i++) begin
      step();
      idle_checks("len0");
    end
    push_len(32'd4);
    run_xfer(1'b0, 1000);
    idle_checks("after0");

    // Length 300 with random backpressure; covers byte wrap at 256.
    push_len(32'd300);
    check("len300_beats", exp_q.size(), 75);
    run_xfer(1'b1, 1000);
    idle_checks("len300");

    // Reset part-way through a 64-byte transfer.
    push_len(32'd64);
    run_xfer(1'b0, 5);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    xfer_model = 16'd0;
    check("midrst_vld",  {31'd0, tx_tvalid}, 32'd0);
    check("midrst_last", {31'd0, tx_tlast}, 32'd0);
    check("midrst_rdy",  {31'd0, rx_tready}, 32'd1);
    check("midrst_xfer", {16'd0, xfer_cnt}, 32'd0);
    rst = 1'b0;
    step();
    push_len(32'd4);
    run_xfer(1'b0, 1000);
    idle_checks("postrst");

    // Lengths 5 and 1 queued back to back.
    push_len(32'd5);
    push_len(32'd1);
    run_xfer(1'b0, 1000);
    idle_checks("b2b");

    // Random short lengths with random backpressure.
    for (int r = 0; r < 4; r++) begin
      rl = 32'($urandom_range(1, 40));
      push_len(rl);
      run_xfer(1'b1, 1000);
      idle_checks("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
